// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : shared UART constants and transmitter state encoding.     |
// | PARITY state exists only when TX_PARITY_EN is defined.               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam int   BAUD_W     = 16;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef TX_PARITY_EN
    , ST_PARITY = 3'd4
`endif
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_fifo : synchronous FIFO, power-of-two DEPTH, async reset.    |
// | Push while full and pop while empty are ignored.                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_push;
  logic             w_pop;

  assign full     = (r_level == LVL_W'(DEPTH));
  assign empty    = (r_level == '0);
  assign level    = r_level;
  assign pop_data = r_mem[r_rd_ptr];
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/tx_uart_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tx_uart_fifo : FIFO-buffered UART transmitter, DATA_BITS-N-1/2.      |
// | Define TX_PARITY_EN to add the parity bit and its config ports.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tx_uart_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 4,
  parameter int LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BAUD_W-1:0]    baud_div,
  input  logic                 cfg_two_stop,
`ifdef TX_PARITY_EN
  input  logic                 cfg_parity_en,
  input  logic                 cfg_parity_odd,
`endif
  input  logic                 start_tx,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx_ready,
  output logic                 tx_pin,
  output logic                 tx_started,
  output logic                 tx_done,
  output logic                 busy,
  output logic [LVL_W-1:0]     fifo_level
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(DATA_BITS - 1);

  tx_state_t            r_state,    w_state_nxt;
  logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
  logic [CNT_W-1:0]     r_bit_cnt,  w_bit_cnt_nxt;
  logic [BAUD_W-1:0]    r_timer,    w_timer_nxt;
  logic [BAUD_W-1:0]    r_baud,     w_baud_nxt;
  logic                 r_two_stop, w_two_stop_nxt;
  logic                 r_stop_cnt, w_stop_cnt_nxt;
  logic                 r_tx_pin,   w_tx_pin_nxt;
  logic                 r_started,  w_started_nxt;
`ifdef TX_PARITY_EN
  logic                 r_par_en,   w_par_en_nxt;
  logic                 r_par_bit,  w_par_bit_nxt;
`endif
  logic                 w_tick;
  logic                 w_done;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [DATA_BITS-1:0] w_head;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (start_tx),
    .push_data (data_in),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .level     (fifo_level)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_timer_nxt    = r_timer;
    w_baud_nxt     = r_baud;
    w_two_stop_nxt = r_two_stop;
    w_stop_cnt_nxt = r_stop_cnt;
    w_tx_pin_nxt   = r_tx_pin;
    w_started_nxt  = 1'b0;
`ifdef TX_PARITY_EN
    w_par_en_nxt   = r_par_en;
    w_par_bit_nxt  = r_par_bit;
`endif
    w_done         = 1'b0;
    w_pop          = 1'b0;
    w_tick         = (r_timer == '0);

    // Every bit lasts r_baud+1 clocks; the timer reloads as each bit ends.
    if (r_state != ST_IDLE)
      w_timer_nxt = w_tick ? r_baud : r_timer - BAUD_W'(1);

    case (r_state)
      ST_START: if (w_tick) begin
        w_state_nxt   = ST_DATA;
        w_tx_pin_nxt  = r_shift[0];
        w_shift_nxt   = r_shift >> 1;
        w_bit_cnt_nxt = c_last_bit;
      end
      ST_DATA: if (w_tick) begin
        if (r_bit_cnt != '0) begin
          w_tx_pin_nxt  = r_shift[0];
          w_shift_nxt   = r_shift >> 1;
          w_bit_cnt_nxt = r_bit_cnt - CNT_W'(1);
        end
`ifdef TX_PARITY_EN
        else if (r_par_en) begin
          w_state_nxt  = ST_PARITY;
          w_tx_pin_nxt = r_par_bit;
        end
`endif
        else begin
          w_state_nxt    = ST_STOP;
          w_tx_pin_nxt   = IDLE_LEVEL;
          w_stop_cnt_nxt = r_two_stop;
        end
      end
`ifdef TX_PARITY_EN
      ST_PARITY: if (w_tick) begin
        w_state_nxt    = ST_STOP;
        w_tx_pin_nxt   = IDLE_LEVEL;
        w_stop_cnt_nxt = r_two_stop;
      end
`endif
      ST_STOP: if (w_tick) begin
        if (r_stop_cnt) begin
          w_stop_cnt_nxt = 1'b0;
        end else begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Frame setup is shared by idle start and gapless back-to-back start.
    if ((r_state == ST_IDLE || w_done) && !w_empty) begin
      w_pop          = 1'b1;
      w_state_nxt    = ST_START;
      w_tx_pin_nxt   = ~IDLE_LEVEL;
      w_started_nxt  = 1'b1;
      w_shift_nxt    = w_head;
      w_baud_nxt     = baud_div;
      w_timer_nxt    = baud_div;
      w_two_stop_nxt = cfg_two_stop;
`ifdef TX_PARITY_EN
      w_par_en_nxt   = cfg_parity_en;
      w_par_bit_nxt  = (^w_head) ^ cfg_parity_odd;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_timer    <= '0;
      r_baud     <= '0;
      r_two_stop <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_tx_pin   <= IDLE_LEVEL;
      r_started  <= 1'b0;
`ifdef TX_PARITY_EN
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_timer    <= w_timer_nxt;
      r_baud     <= w_baud_nxt;
      r_two_stop <= w_two_stop_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_tx_pin   <= w_tx_pin_nxt;
      r_started  <= w_started_nxt;
`ifdef TX_PARITY_EN
      r_par_en   <= w_par_en_nxt;
      r_par_bit  <= w_par_bit_nxt;
`endif
    end
  end

  assign tx_ready   = !w_full;
  assign tx_pin     = r_tx_pin;
  assign tx_started = r_started;
  assign tx_done    = w_done;
  assign busy       = (r_state != ST_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_tx_uart_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tx_uart_fifo : directed bench for tx_uart_fifo with line decoder. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_tx_uart_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] baud_div = 16'd0;
  logic        cfg_two_stop = 1'b0;
`ifdef TX_PARITY_EN
  logic        cfg_parity_en = 1'b0;
  logic        cfg_parity_odd = 1'b0;
`endif
  logic        start_tx = 1'b0;
  logic [7:0]  data_in = 8'd0;
  logic        tx_ready, tx_pin, tx_started, tx_done, busy;
  logic [2:0]  fifo_level;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int wr_cyc = 0;
  int tb_baud = 0;
  bit tb_two = 1'b0;
  bit tb_par = 1'b0;
  int rx_data_q[$], rx_par_q[$], rx_start_q[$], rx_gap_q[$], rx_stop_hi_q[$];
  int done_q[$], started_q[$];

  tx_uart_fifo #(.DATA_BITS(8), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .baud_div       (baud_div),
    .cfg_two_stop   (cfg_two_stop),
`ifdef TX_PARITY_EN
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
`endif
    .start_tx       (start_tx),
    .data_in        (data_in),
    .tx_ready       (tx_ready),
    .tx_pin         (tx_pin),
    .tx_started     (tx_started),
    .tx_done        (tx_done),
    .busy           (busy),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done === 1'b1)    done_q.push_back(cyc);
    if (tx_started === 1'b1) started_q.push_back(cyc);
  end

  // Line decoder: entered on the first clock of a start bit, runs to the frame's last clock.
  task automatic decode_frame(input int gap);
    int b, p, len, pos, start, hi;
    logic [7:0] d;
    logic pb;
    b = tb_baud; p = tb_par ? 1 : 0;
    len = (9 + p + (tb_two ? 2 : 1)) * (b + 1);
    start = cyc; d = 8'd0; pb = 1'b0; hi = 0;
    for (int idx = 1; idx < len; idx++) begin
      @(negedge clk);
      if (rst) return;
      pos = idx / (b + 1);
      if (pos >= 9 + p) begin
        if (tx_pin === 1'b1) hi++;
      end else if (idx % (b + 1) == b / 2) begin
        if (pos >= 1 && pos <= 8) d[pos-1] = tx_pin;
        else if (pos == 9)        pb = tx_pin;
      end
    end
    rx_data_q.push_back(int'(d));
    rx_par_q.push_back(int'(pb));
    rx_start_q.push_back(start);
    rx_gap_q.push_back(gap);
    rx_stop_hi_q.push_back(hi);
  endtask

  initial begin : decoder
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (rst) run = 0;
      else if (tx_pin === 1'b1) run++;
      else if (tx_pin === 1'b0) begin
        decode_frame(run);
        run = 0;
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_q();
    rx_data_q.delete(); rx_par_q.delete(); rx_start_q.delete(); rx_gap_q.delete();
    rx_stop_hi_q.delete(); done_q.delete(); started_q.delete();
  endtask

  task automatic do_write(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    start_tx = 1'b1; data_in = d;
    @(negedge clk);
    start_tx = 1'b0;
    wr_cyc = cyc;
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy !== 1'b0 && k < 20000) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_frames(input int n, input int limit, output bit ok);
    int k = 0;
    while ((rx_data_q.size() < n || done_q.size() < n) && k < limit) begin
      @(negedge clk); k++;
    end
    ok = (rx_data_q.size() >= n && done_q.size() >= n);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (tx_pin !== 1'b1) begin n_mis++; $display("FAIL reset_tx_pin: got %b want 1", tx_pin); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_mis++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    n_cmp++; if (tx_started !== 1'b0) begin n_mis++; $display("FAIL reset_tx_started: got %b want 0", tx_started); end
    n_cmp++; if (tx_done !== 1'b0) begin n_mis++; $display("FAIL reset_tx_done: got %b want 0", tx_done); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_mis++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_8n1();
    bit ok;
    wait_idle(); clear_q();
    baud_div = 16'd434; tb_baud = 434;
    do_write(8'hA5);
    wait_frames(1, 6000, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL 8n1_timeout: frames %0d want 1", rx_data_q.size()); end
    n_cmp++; if (rx_data_q[0] != 8'hA5) begin n_mis++; $display("FAIL 8n1_data: got %0h want a5", rx_data_q[0]); end
    n_cmp++; if (rx_start_q[0] != wr_cyc + 1) begin n_mis++; $display("FAIL 8n1_latency: start %0d want %0d", rx_start_q[0], wr_cyc + 1); end
    n_cmp++; if (started_q.size() != 1 || started_q[0] != rx_start_q[0]) begin n_mis++; $display("FAIL 8n1_started: count %0d at %0d want 1 at %0d", started_q.size(), started_q[0], rx_start_q[0]); end
    n_cmp++; if (rx_stop_hi_q[0] != 435) begin n_mis++; $display("FAIL 8n1_stop: high %0d want 435", rx_stop_hi_q[0]); end
    n_cmp++; if (done_q[0] - rx_start_q[0] != 4349) begin n_mis++; $display("FAIL 8n1_done_time: got %0d want 4349", done_q[0] - rx_start_q[0]); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL 8n1_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_sweep();
    bit ok;
    wait_idle(); clear_q();
    baud_div = 16'd1; tb_baud = 1;
    for (int v = 0; v < 256; v++) begin
      do_write(v[7:0]);
      repeat ($urandom_range(1, 100)) @(negedge clk);
    end
    wait_frames(256, 5000, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL sweep_timeout: frames %0d want 256", rx_data_q.size()); end
    for (int v = 0; v < 256; v++) begin
      n_cmp++; if (rx_data_q[v] != v) begin n_mis++; $display("FAIL sweep_data[%0d]: got %0h want %0h", v, rx_data_q[v], v); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int acc;
    int lvl_exp [5] = '{1, 1, 2, 3, 4};
    wait_idle(); clear_q();
    baud_div = 16'd2; tb_baud = 2;
    acc = 0;
    @(negedge clk);
    while (tx_ready === 1'b1 && acc < 8) begin
      start_tx = 1'b1; data_in = 8'h30 + 8'(acc);
      @(negedge clk);
      acc++;
      if (acc <= 5) begin
        n_cmp++; if (fifo_level !== 3'(lvl_exp[acc-1])) begin n_mis++; $display("FAIL burst_level[%0d]: got %0d want %0d", acc, fifo_level, lvl_exp[acc-1]); end
      end
    end
    n_cmp++; if (acc != 5) begin n_mis++; $display("FAIL burst_accepted: got %0d want 5", acc); end
    data_in = 8'hEE;
    repeat (3) begin
      @(negedge clk);
      n_cmp++; if (tx_ready !== 1'b0 || fifo_level !== 3'd4) begin n_mis++; $display("FAIL full_write: ready %b level %0d want 0/4", tx_ready, fifo_level); end
    end
    start_tx = 1'b0;
    wait_frames(5, 400, ok);
    repeat (100) @(negedge clk);
    n_cmp++; if (!ok || rx_data_q.size() != 5 || started_q.size() != 5) begin n_mis++; $display("FAIL burst_count: frames %0d starts %0d want 5", rx_data_q.size(), started_q.size()); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (rx_data_q[i] != 8'h30 + i) begin n_mis++; $display("FAIL burst_data[%0d]: got %0h want %0h", i, rx_data_q[i], 8'h30 + i); end
    end
    for (int i = 1; i < 5; i++) begin
      n_cmp++; if (rx_gap_q[i] != 0 || rx_start_q[i] - rx_start_q[i-1] != 30) begin n_mis++; $display("FAIL burst_spacing[%0d]: gap %0d period %0d want 0/30", i, rx_gap_q[i], rx_start_q[i] - rx_start_q[i-1]); end
    end
  endtask

  task automatic test_baud_change();
    bit ok;
    int k = 0;
    wait_idle(); clear_q();
    baud_div = 16'd3; tb_baud = 3;
    do_write(8'h5A);
    while (started_q.size() < 1 && k < 100) begin @(negedge clk); k++; end
    @(negedge clk);
    baud_div = 16'd1; tb_baud = 1;
    do_write(8'hC3);
    wait_frames(2, 500, ok);
    n_cmp++; if (!ok || rx_data_q[0] != 8'h5A || rx_data_q[1] != 8'hC3) begin n_mis++; $display("FAIL baud_data: got %0h %0h want 5a c3", rx_data_q[0], rx_data_q[1]); end
    n_cmp++; if (done_q[0] - rx_start_q[0] != 39) begin n_mis++; $display("FAIL baud_old_frame: got %0d want 39", done_q[0] - rx_start_q[0]); end
    n_cmp++; if (rx_start_q[1] - rx_start_q[0] != 40 || rx_gap_q[1] != 0) begin n_mis++; $display("FAIL baud_next_start: period %0d gap %0d want 40/0", rx_start_q[1] - rx_start_q[0], rx_gap_q[1]); end
    n_cmp++; if (done_q[1] - rx_start_q[1] != 19) begin n_mis++; $display("FAIL baud_new_frame: got %0d want 19", done_q[1] - rx_start_q[1]); end
  endtask

  task automatic test_two_stop();
    bit ok;
    wait_idle(); clear_q();
    baud_div = 16'd0; tb_baud = 0;
    cfg_two_stop = 1'b1; tb_two = 1'b1;
    do_write(8'h35);
    do_write(8'hCA);
    wait_frames(2, 200, ok);
    n_cmp++; if (!ok || rx_data_q[0] != 8'h35 || rx_data_q[1] != 8'hCA) begin n_mis++; $display("FAIL two_stop_data: got %0h %0h want 35 ca", rx_data_q[0], rx_data_q[1]); end
    n_cmp++; if (rx_stop_hi_q[0] != 2 || rx_gap_q[1] != 0) begin n_mis++; $display("FAIL two_stop_high: high %0d gap %0d want 2/0", rx_stop_hi_q[0], rx_gap_q[1]); end
    n_cmp++; if (rx_start_q[1] - rx_start_q[0] != 11) begin n_mis++; $display("FAIL two_stop_period: got %0d want 11", rx_start_q[1] - rx_start_q[0]); end
    n_cmp++; if (done_q[1] - rx_start_q[1] != 10) begin n_mis++; $display("FAIL two_stop_done: got %0d want 10", done_q[1] - rx_start_q[1]); end
    cfg_two_stop = 1'b0; tb_two = 1'b0;
  endtask

`ifdef TX_PARITY_EN
  task automatic test_parity();
    bit ok;
    wait_idle(); clear_q();
    baud_div = 16'd0; tb_baud = 0;
    cfg_parity_en = 1'b1; tb_par = 1'b1;
    cfg_parity_odd = 1'b0;
    do_write(8'h07);
    wait_frames(1, 100, ok);
    n_cmp++; if (!ok || rx_data_q[0] != 8'h07 || rx_par_q[0] != 1) begin n_mis++; $display("FAIL parity_even: data %0h par %0d want 07/1", rx_data_q[0], rx_par_q[0]); end
    n_cmp++; if (done_q[0] - rx_start_q[0] != 10) begin n_mis++; $display("FAIL parity_len: got %0d want 10", done_q[0] - rx_start_q[0]); end
    wait_idle(); clear_q();
    cfg_parity_odd = 1'b1;
    do_write(8'h07);
    wait_frames(1, 100, ok);
    n_cmp++; if (!ok || rx_data_q[0] != 8'h07 || rx_par_q[0] != 0) begin n_mis++; $display("FAIL parity_odd: data %0h par %0d want 07/0", rx_data_q[0], rx_par_q[0]); end
    wait_idle();
    cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; tb_par = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    bit ok;
    int k = 0;
    wait_idle(); clear_q();
    baud_div = 16'd3; tb_baud = 3;
    do_write(8'h11);
    do_write(8'h22);
    do_write(8'h33);
    while ((started_q.size() < 1 || cyc < started_q[0] + 12) && k < 200) begin @(negedge clk); k++; end
    n_cmp++; if (fifo_level !== 3'd2) begin n_mis++; $display("FAIL rstmid_level_before: got %0d want 2", fifo_level); end
    rst = 1'b1;
    #1;
    n_cmp++; if (tx_pin !== 1'b1) begin n_mis++; $display("FAIL rstmid_tx_pin: got %b want 1", tx_pin); end
    n_cmp++; if (fifo_level !== 3'd0 || busy !== 1'b0) begin n_mis++; $display("FAIL rstmid_level: level %0d busy %b want 0/0", fifo_level, busy); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    n_cmp++; if (done_q.size() != 0 || rx_data_q.size() != 0) begin n_mis++; $display("FAIL rstmid_no_done: done %0d frames %0d want 0/0", done_q.size(), rx_data_q.size()); end
    clear_q();
    do_write(8'h3C);
    wait_frames(1, 200, ok);
    n_cmp++; if (!ok || rx_data_q[0] != 8'h3C) begin n_mis++; $display("FAIL rstmid_after: got %0h want 3c", rx_data_q[0]); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_sweep();
    test_back_to_back();
    test_baud_change();
    test_two_stop();
`ifdef TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
